spi_reg_master: RTL and testbench

//  SPI mode-0 master that issues single register transactions to the fabric's
//  SPI register slave: 7-bit address, 32-bit data, read or write.

---
 rtl/spi_reg_master.sv | 137 +++++++++++++
 tb/tb_spi_reg_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing single 40-bit register frames: {rd, addr[6:0]} header then 32 data bits, MSB first.
// rdat holds the last read result; timing of chip-select setup/hold/gap and SCLK half-period is parameterised.
module spi_reg_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rd,
   input  logic [6:0]  addr,
   input  logic [31:0] wdat,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdat,
   output logic        spi_csl,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                              : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
   localparam int WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t         state, state_nx;
   logic [HW-1:0]  half_cnt;
   logic [5:0]     bit_cnt;
   logic [WW-1:0]  wait_cnt;
   logic [38:0]    tx_sr;
   logic [31:0]    rx_sr;
   logic           rd_q;
   logic           half_end;
   logic           wait_end;
   logic           bit_last;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      wait_end = 1'b0;
      half_end = (half_cnt == HW'(CLK_DIV - 1));
      bit_last = (bit_cnt == 6'd0);
      case (state)
         IDLE:  if (start) state_nx = SETUP;
         SETUP: begin
            wait_end = (wait_cnt == WW'(CS_SETUP - 1));
            if (wait_end) state_nx = SHIFT;
         end
         SHIFT: if (half_end && spi_sclk && bit_last) state_nx = HOLD;
         HOLD: begin
            wait_end = (wait_cnt == WW'(CS_HOLD - 1));
            if (wait_end) state_nx = GAP;
         end
         GAP: begin
            wait_end = (wait_cnt == WW'(CS_GAP - 1));
            if (wait_end) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The header bit goes straight to mosi at accept, so tx_sr only holds the 39 bits still to send.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         rdat     <= '0;
         spi_csl  <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         wait_cnt <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rd_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_sr    <= {addr, wdat};
                  rd_q     <= rd;
                  busy     <= 1'b1;
                  spi_csl  <= 1'b0;
                  spi_mosi <= rd;
                  half_cnt <= '0;
                  bit_cnt  <= 6'd39;
                  wait_cnt <= '0;
               end
            end
            SETUP: wait_cnt <= wait_end ? '0 : wait_cnt + 1'b1;
            SHIFT: begin
               half_cnt <= half_end ? '0 : half_cnt + 1'b1;
               if (half_end) begin
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                  end else begin
                     spi_sclk <= 1'b0;
                     if (bit_cnt < 6'd32) rx_sr <= {rx_sr[30:0], spi_miso};
                     if (bit_last) begin
                        spi_mosi <= 1'b0;
                     end else begin
                        spi_mosi <= tx_sr[38];
                        tx_sr    <= {tx_sr[37:0], 1'b0};
                        bit_cnt  <= bit_cnt - 6'd1;
                     end
                  end
               end
            end
            HOLD: begin
               wait_cnt <= wait_end ? '0 : wait_cnt + 1'b1;
               if (wait_end) begin
                  spi_csl <= 1'b1;
                  done    <= 1'b1;
                  if (rd_q) rdat <= rx_sr;
               end
            end
            GAP: begin
               wait_cnt <= wait_end ? '0 : wait_cnt + 1'b1;
               if (wait_end) busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: default-timing instance plus a CLK_DIV=1 instance,
// each with a behavioural SPI slave that captures MOSI and returns a programmed word on MISO.
`timescale 1ns/1ps
module tb_spi_reg_master;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start, rd, busy, done, csl, sclk, mosi, miso;
   logic [6:0]  addr;
   logic [31:0] wdat, rdat;

   logic        fStart, fRd, fBusy, fDone, fCsl, fSclk, fMosi, fMiso;
   logic [6:0]  fAddr;
   logic [31:0] fWdat, fRdat;

   spi_reg_master u_dut (
      .clk(clk), .reset(reset), .start(start), .rd(rd), .addr(addr), .wdat(wdat),
      .busy(busy), .done(done), .rdat(rdat), .spi_csl(csl), .spi_sclk(sclk),
      .spi_mosi(mosi), .spi_miso(miso)
   );

   spi_reg_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_fast (
      .clk(clk), .reset(reset), .start(fStart), .rd(fRd), .addr(fAddr), .wdat(fWdat),
      .busy(fBusy), .done(fDone), .rdat(fRdat), .spi_csl(fCsl), .spi_sclk(fSclk),
      .spi_mosi(fMosi), .spi_miso(fMiso)
   );

   // Slave models: capture MOSI on SCLK rise, shift the response out after each SCLK fall past the header.
   logic [5:0]  sCnt = '0, fCnt = '0;
   logic [39:0] sCap = '0, fCap = '0;
   logic [31:0] sResp = '0, fResp = '0;

   always @(negedge csl)  begin sCnt = '0; sCap = '0; end
   always @(posedge sclk) sCap = {sCap[38:0], mosi};
   always @(negedge sclk) sCnt = sCnt + 6'd1;
   always_comb begin
      miso = 1'b0;
      if (sCnt >= 6'd8 && sCnt < 6'd40) miso = sResp[5'(6'd39 - sCnt)];
   end

   always @(negedge fCsl)  begin fCnt = '0; fCap = '0; end
   always @(posedge fSclk) fCap = {fCap[38:0], fMosi};
   always @(negedge fSclk) fCnt = fCnt + 6'd1;
   always_comb begin
      fMiso = 1'b0;
      if (fCnt >= 6'd8 && fCnt < 6'd40) fMiso = fResp[5'(6'd39 - fCnt)];
   end

   typedef struct packed {
      logic [39:0] frame;
      logic [31:0] rdat;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] modelRdat = '0;
   int          total = 0;
   int          bad = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkScoreboard(input string tag);
      exp_t e;
      checkOutput({tag, "_sbq"}, 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput({tag, "_mosi"}, 64'(sCap), 64'(e.frame));
         checkOutput({tag, "_rdat"}, 64'(rdat), 64'(e.rdat));
      end
   endtask

   // One frame on the default instance; k counts negedges after the accept edge.
   task automatic applyStimulus(input logic r, input logic [6:0] a, input logic [31:0] d,
                                input logic [31:0] resp, input bit noisy, input string tag);
      exp_t e;
      int   k, low, kDone, kBusy, dones;
      sResp   = resp;
      e.frame = {r, a, d};
      e.rdat  = r ? resp : modelRdat;
      if (r) modelRdat = resp;
      expQ.push_back(e);
      @(negedge clk);
      start = 1'b1; rd = r; addr = a; wdat = d;
      @(negedge clk);
      rd = ~r; addr = ~a; wdat = ~d;
      k = 0; low = 0; kDone = -1; kBusy = -1; dones = 0;
      while (k < 420) begin
         if (k > 0) @(negedge clk);
         start = (noisy && k < 328) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noisy) wdat = $urandom;
         if (!csl) low++;
         if (done) begin
            dones++;
            if (kDone < 0) begin
               kDone = k;
               checkScoreboard(tag);
            end
         end
         if (!busy && kBusy < 0) kBusy = k;
         if (kBusy >= 0 && k >= kBusy + (noisy ? 72 : 2)) break;
         k++;
      end
      checkOutput({tag, "_latency"}, 64'(kDone), 64'd324);
      checkOutput({tag, "_csl_low"}, 64'(low), 64'd324);
      checkOutput({tag, "_dones"}, 64'(dones), 64'd1);
      checkOutput({tag, "_busy_tail"}, 64'(kBusy - kDone), 64'd4);
   endtask

   initial begin
      int t, nd, gapHigh, dn, lowCnt, k;
      int dt[3];
      reset = 1'b1;
      start = 0; rd = 0; addr = '0; wdat = '0;
      fStart = 0; fRd = 0; fAddr = '0; fWdat = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_rdat", 64'(rdat), 64'd0);
      checkOutput("rst_csl", 64'(csl), 64'd1);
      checkOutput("rst_sclk", 64'(sclk), 64'd0);
      checkOutput("rst_mosi", 64'(mosi), 64'd0);
      checkOutput("rst_fast_csl", 64'(fCsl), 64'd1);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] write 0x02 <= 0xDEADBEEF");
      applyStimulus(1'b0, 7'h02, 32'hDEADBEEF, 32'h12345678, 1'b0, "wr02");

      $display("[TB] read 0x00");
      applyStimulus(1'b1, 7'h00, 32'h0, 32'hC1EF0000, 1'b0, "rd00");

      $display("[TB] start pulses while busy");
      applyStimulus(1'b0, 7'h15, 32'h0BADF00D, 32'h0, 1'b1, "noisy");

      // start held high for three back-to-back writes
      $display("[TB] start held high");
      sResp = '0;
      for (int i = 0; i < 3; i++) expQ.push_back({{1'b0, 7'h33, 32'h01234567}, modelRdat});
      dt = '{0, 0, 0};
      @(negedge clk);
      start = 1'b1; rd = 1'b0; addr = 7'h33; wdat = 32'h01234567;
      t = 0; nd = 0; gapHigh = 0;
      while (t < 1500) begin
         @(negedge clk);
         t++;
         if (csl && busy) gapHigh++;
         if (done) begin
            if (nd < 3) dt[nd] = t;
            nd++;
            checkScoreboard("b2b");
            if (nd == 3) start = 1'b0;
         end
         if (nd >= 3 && !busy) break;
      end
      start = 1'b0;
      checkOutput("b2b_count", 64'(nd), 64'd3);
      checkOutput("b2b_first", 64'(dt[0]), 64'd325);
      checkOutput("b2b_space1", 64'(dt[1] - dt[0]), 64'd329);
      checkOutput("b2b_space2", 64'(dt[2] - dt[1]), 64'd329);
      checkOutput("b2b_gap_high", 64'(gapHigh), 64'd12);

      // reset lands during data bit 20 (accept + 154..161)
      $display("[TB] reset mid-frame");
      @(negedge clk);
      start = 1'b1; rd = 1'b0; addr = 7'h44; wdat = 32'hCAFEF00D;
      @(negedge clk);
      start = 1'b0;
      repeat (158) @(negedge clk);
      checkOutput("mid_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_csl", 64'(csl), 64'd1);
      checkOutput("mid_rst_sclk", 64'(sclk), 64'd0);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_rdat", 64'(rdat), 64'd0);
      checkOutput("mid_rst_mosi", 64'(mosi), 64'd0);
      reset = 1'b0;
      modelRdat = '0;
      dn = 0; lowCnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (done) dn++;
         if (!csl) lowCnt++;
      end
      checkOutput("mid_no_done", 64'(dn), 64'd0);
      checkOutput("mid_no_frame", 64'(lowCnt), 64'd0);
      applyStimulus(1'b0, 7'h7F, 32'h5A5A0FF0, 32'hFFFFFFFF, 1'b0, "after_rst");

      $display("[TB] fast instance read 0x01");
      fResp = 32'hA5A5A5A5;
      @(negedge clk);
      fStart = 1'b1; fRd = 1'b1; fAddr = 7'h01; fWdat = 32'h0;
      @(negedge clk);
      fStart = 1'b0; fRd = 1'b0; fAddr = 7'h7E;
      k = 0;
      while (!fDone && k < 200) begin
         @(negedge clk);
         k++;
      end
      checkOutput("fast_latency", 64'(k), 64'd82);
      checkOutput("fast_rdat", 64'(fRdat), 64'hA5A5A5A5);
      checkOutput("fast_mosi", 64'(fCap), 64'h8100000000);
      @(negedge clk);
      checkOutput("fast_done_pulse", 64'(fDone), 64'd0);
      checkOutput("fast_busy", 64'(fBusy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
